// File: rtl/count_pulse_conditioner.sv
// Key press conditioner: synchronise, debounce, queue presses and
// emit fixed-width clean Count pulses for a downstream ripple counter.
module count_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_HIGH      = 2,
  parameter int PULSE_LOW       = 2,
  parameter int PEND_MAX        = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Key,
  input  logic       Enable,
  output logic       Count,
  output logic       Busy,
  output logic [1:0] Pending,
  output logic       Overflow
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX =
    (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic          s1;
  logic          s2;
  logic          key_d;
  logic          key_q;
  logic [DW-1:0] db_cnt;

  state_t        state;
  state_t        state_n;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_n;
  logic          start;
  logic          ev;
  logic          accept;
  logic          drop;
  logic [1:0]    pend_n;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      key_d  <= 1'b0;
      key_q  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1    <= Key;
      s2    <= s1;
      key_q <= key_d;
      if (s2 != key_d) begin
        if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          key_d  <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Only a rising debounced level with Enable high becomes an event
  assign ev     = key_d & ~key_q & Enable;
  assign accept = ev & ((Pending < 2'(PEND_MAX)) | start);
  assign drop   = ev & ~accept;
  assign pend_n = Pending + {1'b0, accept} - {1'b0, start};

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    start   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Pending != 2'd0) begin
          state_n = HIGH;
          tmr_n   = '0;
          start   = 1'b1;
        end
      end
      HIGH: begin
        if (tmr == TW'(PULSE_HIGH - 1)) begin
          state_n = LOW;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      LOW: begin
        if (tmr == TW'(PULSE_LOW - 1)) begin
          tmr_n = '0;
          if (Pending != 2'd0) begin
            state_n = HIGH;
            start   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tmr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      tmr      <= '0;
      Count    <= 1'b0;
      Pending  <= 2'd0;
      Overflow <= 1'b0;
    end else begin
      state   <= state_n;
      tmr     <= tmr_n;
      Count   <= (state_n == HIGH);
      Pending <= pend_n;
      if (drop) begin
        Overflow <= 1'b1;
      end
    end
  end

  assign Busy = (state != IDLE) | (Pending != 2'd0);

endmodule
